// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A packed word of 4-bit digit codes is captured into a shadow register on a
// load strobe. The shadow is copied to the display register only at a frame
// boundary, which is the GAP->SHOW edge that lights digit 0. As a result, no
// frame ever mixes old and new digits. Between lit digits all anodes are
// switched off for a short gap to suppress ghosting. Leading zeros can
// optionally be blanked.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   digits_i    N_DIGITS packed nibbles; nibble k drives digit k (0 = rightmost)
//   load_i      single-cycle strobe capturing digits_i into the shadow register
//   blank_lz_i  1 = blank leading zeros (sampled on each SHOW entry)
//   an_o        anode enables, active-low
//   seg_o       segments {g,f,e,d,c,b,a}, active-low
//   frame_o     one-cycle pulse on the edge that commits shadow to display
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int SHOW_CYCLES = 27000,
    parameter int GAP_CYCLES  = 270
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic                  load_i,
    input  logic                  blank_lz_i,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [6:0]            seg_o,
    output logic                  frame_o
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    // Code -> active-low {g,f,e,d,c,b,a}. A is a minus sign; B..F are blank.
    function automatic logic [6:0] encode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0111111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [4*N_DIGITS-1:0] shadow_q;
    logic [4*N_DIGITS-1:0] display_q;
    logic [N_DIGITS-1:0]   an_q;
    logic [6:0]            seg_q;
    logic                  frame_q;

    logic [4*N_DIGITS-1:0] shadow_d;
    logic [4*N_DIGITS-1:0] display_d;
    logic [IDX_W-1:0]      idx_d;
    logic                  gap_done;
    logic                  show_done;
    logic                  commit;

    assign gap_done  = (state_q == ST_GAP)  && (cnt_q == CNT_W'(GAP_CYCLES - 1));
    assign show_done = (state_q == ST_SHOW) && (cnt_q == CNT_W'(SHOW_CYCLES - 1));
    assign idx_d     = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    assign commit    = gap_done && (idx_d == '0);

    // A load coinciding with the commit edge is committed directly. This makes
    // it show up in the frame that starts on that edge.
    assign shadow_d  = load_i ? digits_i : shadow_q;
    assign display_d = commit ? shadow_d : display_q;

    // Leading-zero chain, evaluated on the value the display will hold after
    // this edge. This lets the SHOW(0) entry use freshly committed digits.
    // lead_zero[k] is set when every nibble from k up to the top is 0 or B.
    logic [N_DIGITS-1:0] is_zero;
    logic [N_DIGITS-1:0] lead_zero;
    logic [N_DIGITS-1:0] blank_digit;
    logic [6:0]          seg_cand [N_DIGITS];

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib         = display_d[4*gi +: 4];
            assign is_zero[gi] = (nib == 4'h0) || (nib == 4'hB);
            if (gi == N_DIGITS - 1) begin : g_top
                assign lead_zero[gi] = is_zero[gi];
            end else begin : g_lower
                assign lead_zero[gi] = is_zero[gi] & lead_zero[gi+1];
            end
            // Digit 0 always shows, so a value of zero is still visible.
            assign blank_digit[gi] = blank_lz_i & lead_zero[gi] & (gi != 0);
            assign seg_cand[gi]    = blank_digit[gi] ? SEG_BLANK : encode(nib);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_GAP;
            cnt_q     <= '0;
            idx_q     <= IDX_W'(N_DIGITS - 1);
            shadow_q  <= {N_DIGITS{4'hB}};
            display_q <= {N_DIGITS{4'hB}};
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            frame_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            display_q <= display_d;
            frame_q   <= commit;
            case (state_q)
                ST_SHOW: begin
                    if (show_done) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                        an_q    <= '1;
                        seg_q   <= SEG_BLANK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (gap_done) begin
                        state_q <= ST_SHOW;
                        cnt_q   <= '0;
                        idx_q   <= idx_d;
                        an_q    <= ~(N_DIGITS'(1) << idx_d);
                        seg_q   <= seg_cand[idx_d];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with N_DIGITS=4, SHOW_CYCLES=4 and
// GAP_CYCLES=1, which gives a 20-cycle frame. Each frame is sampled on falling
// edges starting from the cycle in which frame_o is high (offset 0). It is then
// compared against hand-computed anode and segment values per cycle.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int SHOW  = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = SHOW + GAP;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_i;
    logic        load_i;
    logic        blank_lz_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        frame_o;

    seg7_scan_driver #(
        .N_DIGITS   (N),
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_i  (digits_i),
        .load_i    (load_i),
        .blank_lz_i(blank_lz_i),
        .an_o      (an_o),
        .seg_o     (seg_o),
        .frame_o   (frame_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] an_s  [FRAME];
    logic [6:0] seg_s [FRAME];
    logic       fr_s  [FRAME];
    int         waits;

    // Packed expected segment words {digit3, digit2, digit1, digit0}
    localparam logic [27:0] F_BLANK = {4{7'b1111111}};
    localparam logic [27:0] F_1234  = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    localparam logic [27:0] F_LZ    = {7'b1111111, 7'b0111111, 7'b1000000, 7'b0010010};
    localparam logic [27:0] F_NOLZ  = {7'b1000000, 7'b0111111, 7'b1000000, 7'b0010010};
    localparam logic [27:0] F_ZERO  = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
    localparam logic [27:0] F_9999  = {4{7'b0010000}};
    localparam logic [27:0] F_2222  = {4{7'b0100100}};

    // Expected anodes at a frame offset: digit d lit for SHOW cycles, then a gap.
    function automatic logic [3:0] exp_an(input int o);
        if ((o % SLOT) >= SHOW) return 4'b1111;
        return ~(4'b0001 << (o / SLOT));
    endfunction

    function automatic logic [6:0] exp_seg(input int o, input logic [27:0] f);
        if ((o % SLOT) >= SHOW) return 7'b1111111;
        return f[7*(o/SLOT) +: 7];
    endfunction

    // Waits (bounded) for frame_o and records one full frame. Loads can be
    // issued at up to two offsets; a load set at offset o is captured on the
    // following rising edge.
    task automatic capture_frame(input int l1, input logic [15:0] v1,
                                 input int l2, input logic [15:0] v2);
        waits = 0;
        do begin
            @(negedge clk);
            load_i = 1'b0;
            waits++;
        end while (frame_o !== 1'b1 && waits < 200);
        if (frame_o !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: frame_o=%b after %0d cycles, required 1", frame_o, waits);
        end
        for (int o = 0; o < FRAME; o++) begin
            if (o > 0) begin
                @(negedge clk);
                load_i = 1'b0;
            end
            an_s[o]  = an_o;
            seg_s[o] = seg_o;
            fr_s[o]  = frame_o;
            if (o == l1) begin digits_i = v1; load_i = 1'b1; end
            if (o == l2) begin digits_i = v2; load_i = 1'b1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load_i = 1'b0; digits_i = '0; blank_lz_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({an_o, seg_o, frame_o} !== {4'b1111, 7'b1111111, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: an=%b seg=%b fr=%b, required 1111 1111111 0", an_o, seg_o, frame_o);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({an_o, seg_o, frame_o} !== {4'b1111, 7'b1111111, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: an=%b seg=%b fr=%b, required 1111 1111111 0", an_o, seg_o, frame_o);
        end
        capture_frame(-1, '0, -1, '0);
        vectors++;
        if (waits !== 1) begin
            miscompares++;
            $display("FAIL first_frame_latency: frame_o after %0d cycles, required 1", waits);
        end
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_BLANK), o == 0}) begin
                miscompares++;
                $display("FAIL first_frame off=%0d: an=%b seg=%b fr=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], fr_s[o], exp_an(o), exp_seg(o, F_BLANK));
            end
        end
    endtask

    task automatic test_load_mid();
        capture_frame(7, 16'h1234, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_BLANK), o == 0}) begin
                miscompares++;
                $display("FAIL load_mid_current off=%0d: an=%b seg=%b fr=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], fr_s[o], exp_an(o), exp_seg(o, F_BLANK));
            end
        end
        capture_frame(-1, '0, -1, '0);
        vectors++;
        if (waits !== 1) begin
            miscompares++;
            $display("FAIL frame_period: frame_o after %0d cycles, required 1", waits);
        end
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_1234), o == 0}) begin
                miscompares++;
                $display("FAIL load_mid_next off=%0d: an=%b seg=%b fr=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], fr_s[o], exp_an(o), exp_seg(o, F_1234));
            end
        end
    endtask

    task automatic test_leading_zero();
        blank_lz_i = 1'b1;
        capture_frame(3, 16'h0A05, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_1234), o == 0}) begin
                miscompares++;
                $display("FAIL lz_no_zeros off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_1234));
            end
        end
        capture_frame(-1, '0, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_LZ), o == 0}) begin
                miscompares++;
                $display("FAIL lz_on off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_LZ));
            end
        end
        blank_lz_i = 1'b0;
        capture_frame(-1, '0, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_NOLZ), o == 0}) begin
                miscompares++;
                $display("FAIL lz_off off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_NOLZ));
            end
        end
    endtask

    task automatic test_all_zero();
        blank_lz_i = 1'b1;
        capture_frame(5, 16'h0000, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_LZ), o == 0}) begin
                miscompares++;
                $display("FAIL zero_prev off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_LZ));
            end
        end
        capture_frame(-1, '0, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_ZERO), o == 0}) begin
                miscompares++;
                $display("FAIL zero_blank off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_ZERO));
            end
        end
    endtask

    task automatic test_commit_bypass();
        // The load at the last offset is captured on the next frame's commit edge.
        capture_frame(FRAME - 1, 16'h9999, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_ZERO), o == 0}) begin
                miscompares++;
                $display("FAIL bypass_prev off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_ZERO));
            end
        end
        capture_frame(-1, '0, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_9999), o == 0}) begin
                miscompares++;
                $display("FAIL bypass_commit off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_9999));
            end
        end
    endtask

    task automatic test_back_to_back();
        capture_frame(2, 16'h1111, 10, 16'h2222);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_9999), o == 0}) begin
                miscompares++;
                $display("FAIL b2b_current off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_9999));
            end
        end
        capture_frame(-1, '0, -1, '0);
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_2222), o == 0}) begin
                miscompares++;
                $display("FAIL b2b_next off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_2222));
            end
        end
    endtask

    task automatic test_reset_mid();
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (frame_o !== 1'b1 && waits < 200);
        repeat (2 * SLOT) @(negedge clk);
        vectors++;
        if (an_o !== 4'b1011) begin
            miscompares++;
            $display("FAIL rstmid_pre: an=%b, required 1011", an_o);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({an_o, seg_o, frame_o} !== {4'b1111, 7'b1111111, 1'b0}) begin
            miscompares++;
            $display("FAIL rstmid_async: an=%b seg=%b fr=%b, required 1111 1111111 0", an_o, seg_o, frame_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        capture_frame(-1, '0, -1, '0);
        vectors++;
        if (waits !== 1) begin
            miscompares++;
            $display("FAIL rstmid_latency: frame_o after %0d cycles, required 1", waits);
        end
        for (int o = 0; o < FRAME; o++) begin
            vectors++;
            if ({an_s[o], seg_s[o], fr_s[o]} !== {exp_an(o), exp_seg(o, F_BLANK), o == 0}) begin
                miscompares++;
                $display("FAIL rstmid_frame off=%0d: an=%b seg=%b, required an=%b seg=%b",
                         o, an_s[o], seg_s[o], exp_an(o), exp_seg(o, F_BLANK));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_mid();
        test_leading_zero();
        test_all_zero();
        test_commit_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
